// File: rtl/load_align_if.sv
// Bus bundle for the load-align unit: pipeline request/response plus the data-memory read port.
interface load_align_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_split;
    logic              rsp_fault;

    // The load unit is the slave; the pipeline plus memory environment is the master.
    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_split, rsp_fault
    );

    modport master (
        output req_valid, req_addr, req_size, req_unsigned, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_split, rsp_fault
    );
endinterface

// File: rtl/load_align_unit.sv
// Multi-cycle load unit: issues aligned word reads, splits word-crossing accesses,
// and extracts/extends byte, half, word or dword fields at any byte offset.
module load_align_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    load_align_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_GAP, S_RD1, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_split_q, rsp_split_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [ADDR_W-1:0] aligned_addr;

    function automatic logic is_illegal(input logic [1:0] size);
        return (1 << size) > BYTES;
    endfunction

    function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [1:0] size);
        return (int'(off) + (1 << size)) > BYTES;
    endfunction

    // Shift the {HI,LO} pair down to the field, then mask or sign-fill above it.
    function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] pair,
                                                  input logic [OFF_W-1:0]    off,
                                                  input logic [1:0]          size,
                                                  input logic                uns);
        logic [2*DATA_W-1:0] shifted;
        logic [DATA_W-1:0]   mask;
        logic                sign;
        int                  bits;
        shifted = pair >> {off, 3'b000};
        bits    = 8 << size;
        if (bits >= DATA_W) begin
            return shifted[DATA_W-1:0];
        end
        mask = {DATA_W{1'b1}} >> (DATA_W - bits);
        sign = |(shifted[DATA_W-1:0] & mask & ~(mask >> 1));
        if (!uns && sign) begin
            return shifted[DATA_W-1:0] | ~mask;
        end
        return shifted[DATA_W-1:0] & mask;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lo_d        = lo_q;
        rsp_data_d  = rsp_data_q;
        rsp_split_d = rsp_split_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    size_d = bus.req_size;
                    uns_d  = bus.req_unsigned;
                    if (is_illegal(bus.req_size) ||
                        (MISALIGN_EN == 0 && crosses(bus.req_addr[OFF_W-1:0], bus.req_size))) begin
                        rsp_data_d  = '0;
                        rsp_split_d = 1'b0;
                        rsp_fault_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_RD0;
                    end
                end
            end
            S_RD0: begin
                if (bus.mem_ack) begin
                    lo_d = bus.mem_rdata;
                    if (crosses(addr_q[OFF_W-1:0], size_q)) begin
                        state_d = S_GAP;
                    end else begin
                        rsp_data_d  = extract({{DATA_W{1'b0}}, bus.mem_rdata},
                                              addr_q[OFF_W-1:0], size_q, uns_q);
                        rsp_split_d = 1'b0;
                        rsp_fault_d = 1'b0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_GAP: state_d = S_RD1;
            S_RD1: begin
                if (bus.mem_ack) begin
                    rsp_data_d  = extract({bus.mem_rdata, lo_q}, addr_q[OFF_W-1:0], size_q, uns_q);
                    rsp_split_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            lo_q        <= '0;
            rsp_data_q  <= '0;
            rsp_split_q <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lo_q        <= lo_d;
            rsp_data_q  <= rsp_data_d;
            rsp_split_q <= rsp_split_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Memory outputs decode straight from state so an async reset drops mem_req at once.
    assign aligned_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.mem_req   = (state_q == S_RD0) || (state_q == S_RD1);
    assign bus.mem_addr  = (state_q == S_RD0) ? aligned_addr :
                           (state_q == S_RD1) ? aligned_addr + ADDR_W'(BYTES) : '0;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_split = rsp_split_q;
    assign bus.rsp_fault = rsp_fault_q;
endmodule
